gf180mcu_ocd_io__in_deglitch: RTL and testbench

Core-side conditioner placed directly downstream of the input pad cell. It consumes the pad's Y output and produces a clean signal for core logic. It synchronises Y into the CLK domain, rejects glitches shorter than a programmable stability window, and emits single-cycle rise/fall pulses. It also keeps a sticky, maskable edge interrupt and drives the pad's PU/PD controls from registered configuration.

---
 rtl/gf180mcu_ocd_io__in_deglitch_if.sv | 30 +++
 rtl/gf180mcu_ocd_io__in_deglitch.sv | 101 ++++++++++
 tb/tb_gf180mcu_ocd_io__in_deglitch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_ocd_io__in_deglitch_if.sv
// Pad-input conditioner signal bundle: pad/config inputs towards the block,
// conditioned level, edge pulses, interrupt and pull controls back out.
interface gf180mcu_ocd_io__in_deglitch_if #(
    parameter int unsigned CNT_W = 8
);
    logic             PAD_Y;
    logic [CNT_W-1:0] FILT_LEN;
    logic [1:0]       IRQ_MODE;
    logic             IRQ_CLR;
    logic             PU_EN;
    logic             PD_EN;
    logic             Y_F;
    logic             RISE;
    logic             FALL;
    logic             IRQ;
    logic             PU;
    logic             PD;

    // Core-side driver of the conditioner
    modport master (
        output PAD_Y, FILT_LEN, IRQ_MODE, IRQ_CLR, PU_EN, PD_EN,
        input  Y_F, RISE, FALL, IRQ, PU, PD
    );

    // The conditioner itself
    modport slave (
        input  PAD_Y, FILT_LEN, IRQ_MODE, IRQ_CLR, PU_EN, PD_EN,
        output Y_F, RISE, FALL, IRQ, PU, PD
    );
endinterface

// File: rtl/gf180mcu_ocd_io__in_deglitch.sv
// Pad input conditioner: two-flop synchroniser, programmable stability filter,
// single-cycle edge pulses, sticky maskable edge interrupt and pull control.
module gf180mcu_ocd_io__in_deglitch #(
    parameter int unsigned CNT_W   = 8,
    parameter bit          RST_VAL = 1'b0
) (
    input logic CLK,
    input logic RN,
    gf180mcu_ocd_io__in_deglitch_if.slave bus
);
    localparam logic [CNT_W-1:0] CntZero = '0;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_yf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             r_irq;
    logic             r_pu;
    logic             r_pd;

    logic [CNT_W-1:0] w_len_m1;
    logic             w_mismatch;
    logic             w_expire;
    logic             w_irq_set;

    // Filter length 0 behaves as 1, so the threshold L-1 saturates at zero
    assign w_len_m1   = (bus.FILT_LEN == CntZero) ? CntZero : (bus.FILT_LEN - CntOne);
    assign w_mismatch = (r_sync2 != r_yf);
    // >= so that shrinking FILT_LEN mid-count takes effect on the next mismatch
    assign w_expire   = w_mismatch && (r_cnt >= w_len_m1);
    assign w_irq_set  = (r_rise && bus.IRQ_MODE[0]) || (r_fall && bus.IRQ_MODE[1]);

    // Two-flop synchroniser; r_sync2 is the only consumer of the pad
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= bus.PAD_Y;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter and filtered level; counter stays within 0..L-1
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_yf  <= RST_VAL;
            r_cnt <= CntZero;
        end else if (!w_mismatch) begin
            r_cnt <= CntZero;
        end else if (w_expire) begin
            r_yf  <= r_sync2;
            r_cnt <= CntZero;
        end else begin
            r_cnt <= r_cnt + CntOne;
        end
    end

    // Edge pulses registered on the same edge as the filtered level update
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_expire && r_sync2;
            r_fall <= w_expire && !r_sync2;
        end
    end

    // Sticky interrupt: a set condition beats a simultaneous clear
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (bus.IRQ_CLR) begin
            r_irq <= 1'b0;
        end
    end

    // Pull controls; a conflicting request releases both so the pad never fights
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_pu <= 1'b0;
            r_pd <= 1'b0;
        end else begin
            r_pu <= bus.PU_EN && !bus.PD_EN;
            r_pd <= bus.PD_EN && !bus.PU_EN;
        end
    end

    assign bus.Y_F  = r_yf;
    assign bus.RISE = r_rise;
    assign bus.FALL = r_fall;
    assign bus.IRQ  = r_irq;
    assign bus.PU   = r_pu;
    assign bus.PD   = r_pd;
endmodule

// File: tb/tb_gf180mcu_ocd_io__in_deglitch.sv
// Directed and randomised bench for the pad input conditioner, checked against
// a behavioural model built from the filter/pulse/interrupt/pull rules.
module tb_gf180mcu_ocd_io__in_deglitch;
    localparam int unsigned CNT_W   = 8;
    localparam bit          RST_VAL = 1'b0;

    logic CLK = 1'b0;
    logic RN;
    int   n_checks = 0;
    int   n_err    = 0;

    gf180mcu_ocd_io__in_deglitch_if #(.CNT_W(CNT_W)) bus ();

    gf180mcu_ocd_io__in_deglitch #(
        .CNT_W  (CNT_W),
        .RST_VAL(RST_VAL)
    ) dut (
        .CLK(CLK),
        .RN (RN),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: pad seen through a 2-sample delay line, mismatch run length
    // compared against max(FILT_LEN,1), pulses and interrupt derived from updates.
    logic m_pipe [0:1] = '{RST_VAL, RST_VAL};
    logic m_yf   = RST_VAL;
    int   m_run  = 0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    logic m_irq  = 1'b0;
    logic m_pu   = 1'b0;
    logic m_pd   = 1'b0;

    always @(posedge CLK or negedge RN) begin : model_b
        logic v;
        logic upd;
        int   len;
        int   run;
        if (!RN) begin
            m_pipe <= '{RST_VAL, RST_VAL};
            m_yf   <= RST_VAL;
            m_run  <= 0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            m_irq  <= 1'b0;
            m_pu   <= 1'b0;
            m_pd   <= 1'b0;
        end else begin
            v   = m_pipe[1];
            len = (int'(bus.FILT_LEN) == 0) ? 1 : int'(bus.FILT_LEN);
            run = (v != m_yf) ? m_run + 1 : 0;
            upd = (v != m_yf) && (run >= len);
            m_pipe[1] <= m_pipe[0];
            m_pipe[0] <= bus.PAD_Y;
            m_yf   <= upd ? v : m_yf;
            m_run  <= upd ? 0 : run;
            m_rise <= upd && v;
            m_fall <= upd && !v;
            if ((m_rise && bus.IRQ_MODE[0]) || (m_fall && bus.IRQ_MODE[1])) m_irq <= 1'b1;
            else if (bus.IRQ_CLR) m_irq <= 1'b0;
            m_pu <= bus.PU_EN && !bus.PD_EN;
            m_pd <= bus.PD_EN && !bus.PU_EN;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model
    task automatic chk_model();
        chk("model_yf",   32'(bus.Y_F),     32'(m_yf));
        chk("model_rise", 32'(bus.RISE),    32'(m_rise));
        chk("model_fall", 32'(bus.FALL),    32'(m_fall));
        chk("model_irq",  32'(bus.IRQ),     32'(m_irq));
        chk("model_pu",   32'(bus.PU),      32'(m_pu));
        chk("model_pd",   32'(bus.PD),      32'(m_pd));
        chk("model_cnt",  32'(dut.r_cnt),   32'(m_run));
        chk("never_both", 32'(bus.RISE && bus.FALL), 32'd0);
    endtask

    // One clock edge, then sample 1 ns later
    task automatic tick();
        @(posedge CLK);
        #1;
        chk_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RN           = 1'b0;
        bus.PAD_Y    = 1'b1;
        bus.FILT_LEN = 8'd4;
        bus.IRQ_MODE = 2'b01;
        bus.IRQ_CLR  = 1'b0;
        bus.PU_EN    = 1'b0;
        bus.PD_EN    = 1'b0;
        #3;
        chk("rst_yf",   32'(bus.Y_F),  32'(RST_VAL));
        chk("rst_rise", 32'(bus.RISE), 32'd0);
        chk("rst_fall", 32'(bus.FALL), 32'd0);
        chk("rst_irq",  32'(bus.IRQ),  32'd0);
        chk("rst_pu",   32'(bus.PU),   32'd0);
        chk("rst_pd",   32'(bus.PD),   32'd0);
        chk("rst_cnt",  32'(dut.r_cnt), 32'd0);
        @(posedge CLK);
        #1;
        RN = 1'b1;

        // Pad high through reset, L=4: Y_F rises after edge 6
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("pwr_yf_low", 32'(bus.Y_F), 32'd0);
        end
        tick();
        chk("pwr_yf_e6",  32'(bus.Y_F),  32'd1);
        chk("pwr_rise",   32'(bus.RISE), 32'd1);
        tick();
        chk("pwr_rise_1c", 32'(bus.RISE), 32'd0);
        chk("pwr_irq",     32'(bus.IRQ),  32'd1);
        bus.IRQ_CLR = 1'b1;
        tick();
        chk("irq_clr", 32'(bus.IRQ), 32'd0);
        bus.IRQ_CLR = 1'b0;

        // Glitch shorter than L=5 is rejected
        bus.PAD_Y    = 1'b0;
        bus.FILT_LEN = 8'd1;
        ticks(4);
        chk("pre_glitch_yf", 32'(bus.Y_F), 32'd0);
        bus.FILT_LEN = 8'd5;
        bus.PAD_Y    = 1'b1;
        ticks(3);
        bus.PAD_Y = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_yf",   32'(bus.Y_F),  32'd0);
            chk("glitch_rise", 32'(bus.RISE), 32'd0);
        end
        chk("glitch_cnt", 32'(dut.r_cnt), 32'd0);

        // FILT_LEN 0 and 1 both mean no filtering: update after edge 3
        for (int fl = 0; fl < 2; fl++) begin
            bus.FILT_LEN = 8'(fl);
            bus.PAD_Y    = 1'b1;
            ticks(2);
            chk("nf_rise_early", 32'(bus.Y_F), 32'd0);
            tick();
            chk("nf_rise_yf", 32'(bus.Y_F),  32'd1);
            chk("nf_rise",    32'(bus.RISE), 32'd1);
            tick();
            bus.PAD_Y = 1'b0;
            ticks(2);
            chk("nf_fall_early", 32'(bus.Y_F), 32'd1);
            tick();
            chk("nf_fall_yf", 32'(bus.Y_F),  32'd0);
            chk("nf_fall",    32'(bus.FALL), 32'd1);
            tick();
            chk("nf_fall_1c", 32'(bus.FALL), 32'd0);
        end

        // Fall-only interrupt, set beats clear, then explicit clear
        bus.IRQ_CLR = 1'b1;
        tick();
        bus.IRQ_CLR  = 1'b0;
        bus.IRQ_MODE = 2'b10;
        bus.FILT_LEN = 8'd1;
        bus.PAD_Y    = 1'b1;
        ticks(3);
        chk("m10_rise", 32'(bus.RISE), 32'd1);
        ticks(2);
        chk("m10_rise_no_irq", 32'(bus.IRQ), 32'd0);
        bus.PAD_Y = 1'b0;
        ticks(3);
        chk("m10_fall", 32'(bus.FALL), 32'd1);
        bus.IRQ_CLR = 1'b1;
        tick();
        chk("set_wins", 32'(bus.IRQ), 32'd1);
        bus.IRQ_CLR = 1'b0;
        tick();
        chk("irq_sticky", 32'(bus.IRQ), 32'd1);
        bus.IRQ_CLR = 1'b1;
        tick();
        chk("irq_reclr", 32'(bus.IRQ), 32'd0);
        bus.IRQ_CLR = 1'b0;

        // Pull control
        bus.PU_EN = 1'b1;
        tick();
        chk("pu_only_pu", 32'(bus.PU), 32'd1);
        chk("pu_only_pd", 32'(bus.PD), 32'd0);
        bus.PD_EN = 1'b1;
        tick();
        chk("both_pu", 32'(bus.PU), 32'd0);
        chk("both_pd", 32'(bus.PD), 32'd0);
        bus.PU_EN = 1'b0;
        tick();
        chk("pd_only_pu", 32'(bus.PU), 32'd0);
        chk("pd_only_pd", 32'(bus.PD), 32'd1);

        // Long filter shortened mid-count
        bus.IRQ_MODE = 2'b01;
        bus.FILT_LEN = 8'd200;
        bus.PAD_Y    = 1'b1;
        ticks(52);
        chk("long_cnt50", 32'(dut.r_cnt), 32'd50);
        chk("long_yf",    32'(bus.Y_F),   32'd0);
        bus.FILT_LEN = 8'd10;
        tick();
        chk("shrink_yf",   32'(bus.Y_F),  32'd1);
        chk("shrink_rise", 32'(bus.RISE), 32'd1);
        tick();

        // Reset mid-count: discard count, no pulse from the reset itself
        bus.PAD_Y    = 1'b0;
        bus.FILT_LEN = 8'd200;
        ticks(20);
        chk("mid_cnt", 32'(dut.r_cnt), 32'd18);
        #2;
        RN = 1'b0;
        #1;
        chk("mid_rst_yf",   32'(bus.Y_F),   32'(RST_VAL));
        chk("mid_rst_cnt",  32'(dut.r_cnt), 32'd0);
        chk("mid_rst_fall", 32'(bus.FALL),  32'd0);
        chk("mid_rst_rise", 32'(bus.RISE),  32'd0);
        #1;
        RN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_fall", 32'(bus.FALL), 32'd0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) bus.FILT_LEN = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) bus.PAD_Y = ~bus.PAD_Y;
            if (i % 25 == 0) bus.IRQ_MODE = 2'($urandom_range(0, 3));
            bus.IRQ_CLR = ($urandom_range(0, 7) == 0);
            bus.PU_EN   = 1'($urandom_range(0, 1));
            bus.PD_EN   = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
